// File: rtl/mips_cpu_pkg.sv
// Shared MIPS CPU definitions: reset vector, halt address, NOP encoding,
// instruction-memory state type and the CPU's byte-order helper.
package mips_cpu_pkg;

    localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;
    localparam logic [31:0] HALT_ADDR    = 32'h00000000;
    localparam logic [31:0] INSTR_NOP    = 32'h00000000;

    typedef enum logic {
        LOAD  = 1'b0,
        READY = 1'b1
    } instr_mem_state_t;

    // Reverses byte order between MIPS big-endian values and the CPU's bus order.
    function automatic logic [31:0] byte_swap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/mips_cpu_instr_memory_if.sv
// Load-stream and fetch-port signals between a loader/CPU (master) and the
// instruction memory (slave).
interface mips_cpu_instr_memory_if #(
    parameter int DEPTH = 256
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          load_start;
    logic          load_valid;
    logic          load_ready;
    logic [31:0]   load_data;
    logic          load_last;
    logic          load_done;
    logic [CW-1:0] words_loaded;
    logic [31:0]   instr_address;
    logic [31:0]   instr_readdata;
    logic          addr_fault;

    modport master (
        output load_start, load_valid, load_data, load_last, instr_address,
        input  load_ready, load_done, words_loaded, instr_readdata, addr_fault
    );

    modport slave (
        input  load_start, load_valid, load_data, load_last, instr_address,
        output load_ready, load_done, words_loaded, instr_readdata, addr_fault
    );

endinterface

// File: rtl/mips_instr_mem_array.sv
// DEPTH x 32 storage: synchronous write, asynchronous read so the CPU sees
// its instruction in the same cycle it presents the address.
module mips_instr_mem_array #(
    parameter int DEPTH = 256,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/mips_cpu_instr_memory.sv
// Instruction-memory responder: streamed image load after reset, zero-latency
// fetch in CPU byte order, sticky flag for illegal fetch addresses.
module mips_cpu_instr_memory
    import mips_cpu_pkg::*;
#(
    parameter int          DEPTH     = 256,
    parameter logic [31:0] BASE_ADDR = RESET_VECTOR,
    parameter bit          BYTE_SWAP = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    mips_cpu_instr_memory_if.slave   bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    instr_mem_state_t state_reg;
    logic [AW-1:0]    wr_ptr_reg;
    logic [CW-1:0]    words_loaded_reg;
    logic             addr_fault_reg;
    logic             load_ready_reg;
    logic             load_done_reg;

    logic             accept;
    logic             mem_we;
    logic [31:0]      offset;
    logic             aligned;
    logic             in_range;
    logic             is_halt;
    logic [AW-1:0]    rd_index;
    logic [31:0]      rd_word;
    logic             hit;
    logic             fetch_fault;

    assign accept = bus.load_valid && load_ready_reg;
    // A load_start in the same cycle discards the offered word.
    assign mem_we = accept && !bus.load_start;

    // Unsigned subtraction: addresses below BASE_ADDR wrap high and miss.
    assign offset   = bus.instr_address - BASE_ADDR;
    assign aligned  = (offset[1:0] == 2'b00);
    assign in_range = (offset[31:AW+2] == '0);
    assign rd_index = offset[AW+1:2];
    assign is_halt  = (bus.instr_address == HALT_ADDR);

    assign hit = (state_reg == READY) && !is_halt && aligned && in_range &&
                 ({1'b0, rd_index} < words_loaded_reg);
    assign fetch_fault = (state_reg == READY) && !is_halt && !(aligned && in_range);

    mips_instr_mem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_ptr_reg),
        .wdata (bus.load_data),
        .raddr (rd_index),
        .rdata (rd_word)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg        <= LOAD;
            wr_ptr_reg       <= '0;
            words_loaded_reg <= '0;
            addr_fault_reg   <= 1'b0;
            load_ready_reg   <= 1'b1;
            load_done_reg    <= 1'b0;
        end else begin
            if (fetch_fault) begin
                addr_fault_reg <= 1'b1;
            end
            if (bus.load_start) begin
                state_reg        <= LOAD;
                wr_ptr_reg       <= '0;
                words_loaded_reg <= '0;
                load_ready_reg   <= 1'b1;
                load_done_reg    <= 1'b0;
            end else if (accept) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
                if (words_loaded_reg != CW'(DEPTH)) begin
                    words_loaded_reg <= words_loaded_reg + CW'(1);
                end
                // Filling the last slot ends the image; nothing wraps over word 0.
                if (bus.load_last || (wr_ptr_reg == AW'(DEPTH - 1))) begin
                    state_reg      <= READY;
                    load_ready_reg <= 1'b0;
                    load_done_reg  <= 1'b1;
                end
            end
        end
    end

    assign bus.load_ready     = load_ready_reg;
    assign bus.load_done      = load_done_reg;
    assign bus.words_loaded   = words_loaded_reg;
    assign bus.addr_fault     = addr_fault_reg;
    assign bus.instr_readdata = hit ? (BYTE_SWAP ? byte_swap32(rd_word) : rd_word)
                                    : INSTR_NOP;

endmodule
